// File: rtl/gbc_vram_read_scheduler.sv
// rtl/gbc_vram_read_scheduler.sv - scaled, centred GBC frame-buffer read sequencer for the VGA raster
// Optional VRAM_SCANLINE_EN: halve colour on the last replicated line of each source row.
module gbc_vram_read_scheduler #(
  parameter int SRC_H        = 160,
  parameter int SRC_V        = 144,
  parameter int SCALE        = 4,
  parameter int X_OFFSET     = 320,
  parameter int Y_OFFSET     = 72,
  parameter int ADDR_WIDTH   = 15,
  parameter int VRAM_LATENCY = 1
) (
  input  logic                  i_clkPixel,
  input  logic                  i_reset,
  input  logic                  i_hSync,
  input  logic                  i_vSync,
  input  logic                  i_active,
  input  logic [15:0]           i_x,
  input  logic [15:0]           i_y,
  input  logic [7:0]            i_vramData,
  output logic [ADDR_WIDTH-1:0] o_vramReadAddr,
  output logic                  o_hSync,
  output logic                  o_vSync,
  output logic                  o_inWindow,
  output logic [2:0]            o_red,
  output logic [2:0]            o_green,
  output logic [1:0]            o_blue
);

  localparam int DEPTH = 2 + VRAM_LATENCY;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [15:0] X_START = 16'(X_OFFSET - 1);
  localparam logic [15:0] X_LO    = 16'(X_OFFSET);
  localparam logic [15:0] X_HI    = 16'(X_OFFSET + SRC_H * SCALE);
  localparam logic [15:0] Y_LO    = 16'(Y_OFFSET);
  localparam logic [15:0] Y_HI    = 16'(Y_OFFSET + SRC_V * SCALE);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SRC_H);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'((SRC_V - 1) * SRC_H);
  localparam logic [7:0]            SRC_X_LAST = 8'(SRC_H - 1);
  localparam logic [SUB_W-1:0]      SUB_LAST   = SUB_W'(SCALE - 1);

  localparam logic [2:0] S_TOP      = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LINE_END = 3'd2;
  localparam logic [2:0] S_WAIT_X   = 3'd3;
  localparam logic [2:0] S_BOTTOM   = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [7:0]            src_x;
  logic [SUB_W-1:0]      x_sub;
  logic [SUB_W-1:0]      y_sub;
  logic                  frame_ok;

  logic frame_start;
  logic in_window;

  assign frame_start = (i_x == 16'd0) && (i_y == 16'd0);
  assign in_window   = i_active && (i_x >= X_LO) && (i_x < X_HI) && (i_y >= Y_LO) && (i_y < Y_HI);

  // frame_ok keeps a reset-interrupted frame dark until the raster restarts.
  always_ff @(posedge i_clkPixel) begin
    if (i_reset) begin
      state          <= S_TOP;
      row_base       <= '0;
      src_x          <= '0;
      x_sub          <= '0;
      y_sub          <= '0;
      frame_ok       <= 1'b0;
      o_vramReadAddr <= '0;
    end else if (frame_start) begin
      state          <= S_TOP;
      row_base       <= '0;
      src_x          <= '0;
      x_sub          <= '0;
      y_sub          <= '0;
      frame_ok       <= 1'b1;
      o_vramReadAddr <= '0;
    end else begin
      o_vramReadAddr <= (state == S_FETCH) ? row_base + ADDR_WIDTH'(src_x) : '0;
      case (state)
        S_TOP: begin
          row_base <= '0;
          y_sub    <= '0;
          if (frame_ok && i_y == Y_LO && i_x == X_START) begin
            state <= S_FETCH;
            src_x <= '0;
            x_sub <= '0;
          end
        end
        S_FETCH: begin
          if (x_sub == SUB_LAST) begin
            x_sub <= '0;
            src_x <= src_x + 8'd1;
            if (src_x == SRC_X_LAST) state <= S_LINE_END;
          end else begin
            x_sub <= x_sub + SUB_W'(1);
          end
        end
        S_LINE_END: begin
          if (y_sub == SUB_LAST) begin
            y_sub    <= '0;
            row_base <= row_base + ROW_STEP;
            state    <= (row_base == LAST_ROW) ? S_BOTTOM : S_WAIT_X;
          end else begin
            y_sub <= y_sub + SUB_W'(1);
            state <= S_WAIT_X;
          end
        end
        S_WAIT_X: begin
          if (i_x == X_START) begin
            state <= S_FETCH;
            src_x <= '0;
            x_sub <= '0;
          end
        end
        default: state <= S_BOTTOM;
      endcase
    end
  end

  logic [DEPTH-1:0] win_pipe;
  logic [DEPTH-1:0] hs_pipe;
  logic [DEPTH-1:0] vs_pipe;
  logic             dim;
  logic [2:0]       red_n;
  logic [2:0]       green_n;
  logic [1:0]       blue_n;

`ifdef VRAM_SCANLINE_EN
  logic [DEPTH-1:0][SUB_W-1:0] ysub_pipe;

  always_ff @(posedge i_clkPixel) begin
    if (i_reset) ysub_pipe <= '0;
    else         ysub_pipe <= {ysub_pipe[DEPTH-2:0], y_sub};
  end
`endif

  always_comb begin
    dim = 1'b0;
`ifdef VRAM_SCANLINE_EN
    dim = (ysub_pipe[DEPTH-2] == SUB_LAST);
`endif
    red_n   = dim ? {1'b0, i_vramData[7:6]} : i_vramData[7:5];
    green_n = dim ? {1'b0, i_vramData[4:3]} : i_vramData[4:2];
    blue_n  = dim ? {1'b0, i_vramData[1]}   : i_vramData[1:0];
  end

  // Colour is gated one stage early so it lands together with o_inWindow.
  always_ff @(posedge i_clkPixel) begin
    if (i_reset) begin
      win_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      o_red    <= '0;
      o_green  <= '0;
      o_blue   <= '0;
    end else begin
      win_pipe <= {win_pipe[DEPTH-2:0], frame_ok & in_window};
      hs_pipe  <= {hs_pipe[DEPTH-2:0], i_hSync};
      vs_pipe  <= {vs_pipe[DEPTH-2:0], i_vSync};
      o_red    <= win_pipe[DEPTH-2] ? red_n   : 3'd0;
      o_green  <= win_pipe[DEPTH-2] ? green_n : 3'd0;
      o_blue   <= win_pipe[DEPTH-2] ? blue_n  : 2'd0;
    end
  end

  assign o_hSync    = hs_pipe[DEPTH-1];
  assign o_vSync    = vs_pipe[DEPTH-1];
  assign o_inWindow = win_pipe[DEPTH-1];

endmodule

// File: tb/tb_gbc_vram_read_scheduler.sv
// tb/tb_gbc_vram_read_scheduler.sv - bench for gbc_vram_read_scheduler (default and reduced geometry)
// Model maps raster coordinates straight to source addresses; build with VRAM_SCANLINE_EN to cover dimming.
module tb_gbc_vram_read_scheduler;

  localparam int AW = 15;
  localparam int PH [2]  = '{160, 6};
  localparam int PV [2]  = '{144, 4};
  localparam int PS [2]  = '{4, 2};
  localparam int PXO [2] = '{320, 3};
  localparam int PYO [2] = '{72, 2};
`ifdef VRAM_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, hs, vs, act;
  logic [15:0]   x [2];
  logic [15:0]   y [2];
  logic [7:0]    vd [2];
  logic [AW-1:0] addr [2];
  logic [1:0]    o_hs, o_vs, o_win;
  logic [2:0]    red [2];
  logic [2:0]    green [2];
  logic [1:0]    blue [2];

  gbc_vram_read_scheduler dut_a (
    .i_clkPixel(clk), .i_reset(rst[0]), .i_hSync(hs[0]), .i_vSync(vs[0]), .i_active(act[0]),
    .i_x(x[0]), .i_y(y[0]), .i_vramData(vd[0]), .o_vramReadAddr(addr[0]),
    .o_hSync(o_hs[0]), .o_vSync(o_vs[0]), .o_inWindow(o_win[0]),
    .o_red(red[0]), .o_green(green[0]), .o_blue(blue[0]));

  gbc_vram_read_scheduler #(.SRC_H(6), .SRC_V(4), .SCALE(2), .X_OFFSET(3), .Y_OFFSET(2)) dut_b (
    .i_clkPixel(clk), .i_reset(rst[1]), .i_hSync(hs[1]), .i_vSync(vs[1]), .i_active(act[1]),
    .i_x(x[1]), .i_y(y[1]), .i_vramData(vd[1]), .o_vramReadAddr(addr[1]),
    .o_hSync(o_hs[1]), .o_vSync(o_vs[1]), .o_inWindow(o_win[1]),
    .o_red(red[1]), .o_green(green[1]), .o_blue(blue[1]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [1:0] chk_data;
  logic       vforce;
  logic [7:0] vforce_val;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // VRAM with one cycle of read latency
  always @(posedge clk) begin
    vd[0] <= vforce ? vforce_val : pat(addr[0]);
    vd[1] <= vforce ? vforce_val : pat(addr[1]);
  end

  logic          armed [2];
  logic [AW-1:0] m_addr [2];
  logic [7:0]    m_vd [2];
  logic [2:0]    pw [2];
  logic [2:0]    ph [2];
  logic [2:0]    pv [2];
  int            py [2][3];
  logic [2:0]    m_r [2];
  logic [2:0]    m_g [2];
  logic [1:0]    m_b [2];

  task automatic model_step(input int k);
    int xi, yi, s;
    logic raw, dim;
    logic [7:0] d;
    xi  = int'(x[k]);
    yi  = int'(y[k]);
    s   = PS[k];
    raw = xi >= PXO[k] && xi < PXO[k] + PH[k] * s && yi >= PYO[k] && yi < PYO[k] + PV[k] * s;
    d   = m_vd[k];
    dim = SCAN && (py[k][1] == s - 1);
    if (rst[k] || !pw[k][1]) begin
      m_r[k] = 3'd0; m_g[k] = 3'd0; m_b[k] = 2'd0;
    end else if (dim) begin
      m_r[k] = d[7:5] >> 1; m_g[k] = d[4:2] >> 1; m_b[k] = d[1:0] >> 1;
    end else begin
      m_r[k] = d[7:5]; m_g[k] = d[4:2]; m_b[k] = d[1:0];
    end
    m_vd[k] = vforce ? vforce_val : pat(m_addr[k]);
    if (rst[k]) begin
      m_addr[k] = '0; pw[k] = '0; ph[k] = '0; pv[k] = '0; armed[k] = 1'b0;
      for (int i = 0; i < 3; i++) py[k][i] = 0;
    end else begin
      m_addr[k] = (armed[k] && raw) ? AW'((yi - PYO[k]) / s * PH[k] + (xi - PXO[k]) / s) : '0;
      pw[k] = {pw[k][1:0], armed[k] & act[k] & raw};
      ph[k] = {ph[k][1:0], hs[k]};
      pv[k] = {pv[k][1:0], vs[k]};
      py[k][2] = py[k][1];
      py[k][1] = py[k][0];
      py[k][0] = raw ? (yi - PYO[k]) % s : 0;
      if (xi == 0 && yi == 0) armed[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("hsync[%0d]", k), 32'(o_hs[k]), 32'(ph[k][2]));
        check($sformatf("vsync[%0d]", k), 32'(o_vs[k]), 32'(pv[k][2]));
        check($sformatf("inwin[%0d]", k), 32'(o_win[k]), 32'(pw[k][2]));
        if (chk_data[k]) begin
          check($sformatf("addr[%0d]", k), 32'(addr[k]), 32'(m_addr[k]));
          check($sformatf("rgb[%0d]", k), {24'd0, red[k], green[k], blue[k]}, {24'd0, m_r[k], m_g[k], m_b[k]});
        end
      end
    end
  end

  task automatic step(input int k, input int xi, input int yi);
    x[k]   = 16'(xi);
    y[k]   = 16'(yi);
    act[k] = (k == 0) ? (xi < 1280 && yi < 720) : (xi < 17 && yi < 11);
    hs[k]  = (xi % 8 == 5);
    vs[k]  = (yi % 4 == 3);
    @(posedge clk);
    #1;
  endtask

  task automatic rgb_is(input string name, input int k, input int r, input int g, input int b);
    check(name, {24'd0, red[k], green[k], blue[k]}, 32'((r << 5) | (g << 2) | b));
  endtask

  task automatic frame_b(input int mode, input int rx, input int ry);
    for (int yi = 0; yi < 12; yi++) begin
      for (int xi = 0; xi < 20; xi++) begin
        rst[1] = (yi == ry && xi == rx);
        step(1, xi, yi);
        if (mode == 1 && yi == 7 && xi == 12) begin
          check("b black after reset win", 32'(o_win[1]), 32'd0);
          check("b black after reset addr", 32'(addr[1]), 32'd0);
        end
        if (mode == 2) begin
          if (yi == 2 && xi == 3)  check("b first addr", 32'(addr[1]), 32'd0);
          if (yi == 2 && xi == 4)  check("b win before", 32'(o_win[1]), 32'd0);
          if (yi == 2 && xi == 5)  check("b addr x5", 32'(addr[1]), 32'd1);
          if (yi == 2 && xi == 5)  check("b win rise", 32'(o_win[1]), 32'd1);
          if (yi == 3 && xi == 3)  check("b row repeat", 32'(addr[1]), 32'd0);
          if (yi == 4 && xi == 3)  check("b second row", 32'(addr[1]), 32'd6);
          if (yi == 9 && xi == 14) check("b last addr", 32'(addr[1]), 32'd23);
          if (yi == 9 && xi == 15) check("b past window", 32'(addr[1]), 32'd0);
        end
      end
    end
    rst[1] = 1'b0;
  endtask

  initial begin
    rst = 2'b11; act = '0; hs = '0; vs = '0;
    x[0] = 16'd400; y[0] = 16'd100; x[1] = 16'd0; y[1] = 16'd0;
    chk_data = 2'b11; vforce = 1'b1; vforce_val = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      armed[k] = 1'b0; m_addr[k] = '0; m_vd[k] = '0; pw[k] = '0; ph[k] = '0; pv[k] = '0;
      m_r[k] = '0; m_g[k] = '0; m_b[k] = '0;
      for (int i = 0; i < 3; i++) py[k][i] = 0;
    end

    for (int i = 0; i < 5; i++) step(0, 403 + i, 100);
    check("reset addr", 32'(addr[0]), 32'd0);
    check("reset hsync", 32'(o_hs[0]), 32'd0);
    check("reset inwin", 32'(o_win[0]), 32'd0);
    rgb_is("reset rgb", 0, 0, 0, 0);

    rst = 2'b00;
    for (int i = 0; i < 6; i++) step(0, 408 + i, 100);
    check("released inwin", 32'(o_win[0]), 32'd0);
    rgb_is("released rgb", 0, 0, 0, 0);
    vforce = 1'b0;

    step(0, 0, 0);
    for (int yi = 72; yi <= 76; yi++) begin
      vforce     = (yi == 74 || yi == 75);
      vforce_val = (yi == 74) ? 8'hE5 : 8'hFF;
      for (int xi = 318; xi <= 962; xi++) begin
        step(0, xi, yi);
        if (yi == 72 && xi >= 320 && xi <= 323) check("addr first 4", 32'(addr[0]), 32'd0);
        if (yi == 72 && xi == 324) check("addr x324", 32'(addr[0]), 32'd1);
        if (yi == 72 && xi == 321) check("inwin before", 32'(o_win[0]), 32'd0);
        if (yi == 72 && xi == 322) check("inwin rise", 32'(o_win[0]), 32'd1);
        if (yi == 74 && xi == 402) rgb_is("rgb E5", 0, 7, 1, 1);
        if (yi == 74 && xi == 962) rgb_is("rgb E5 outside", 0, 0, 0, 0);
        if (yi == 75 && xi == 402) begin
          if (SCAN) rgb_is("rgb FF scanline", 0, 3, 3, 1);
          else      rgb_is("rgb FF", 0, 7, 7, 3);
        end
        if (yi == 75 && xi == 959) check("addr line end", 32'(addr[0]), 32'd159);
        if (yi == 75 && xi == 960) check("addr after window", 32'(addr[0]), 32'd0);
        if (yi == 75 && xi == 962) rgb_is("rgb after window", 0, 0, 0, 0);
        if (yi == 76 && xi == 320) check("addr second row", 32'(addr[0]), 32'd160);
      end
    end
    vforce = 1'b0;

    chk_data[0] = 1'b0;
    for (int xi = 319; xi < 500; xi++) step(0, xi, 300);
    rst[0] = 1'b1;
    step(0, 500, 300);
    rst[0] = 1'b0;
    chk_data[0] = 1'b1;
    for (int xi = 501; xi <= 962; xi++) step(0, xi, 300);
    for (int xi = 318; xi <= 962; xi++) begin
      step(0, xi, 301);
      if (xi == 643) begin
        check("reset abort inwin", 32'(o_win[0]), 32'd0);
        check("reset abort addr", 32'(addr[0]), 32'd0);
        rgb_is("reset abort rgb", 0, 0, 0, 0);
      end
    end

    step(0, 0, 0);
    for (int xi = 318; xi <= 962; xi++) begin
      step(0, xi, 72);
      if (xi == 328) check("restart addr", 32'(addr[0]), 32'd2);
    end
    step(0, 0, 0);

    frame_b(0, -1, -1);
    frame_b(1, 8, 5);
    frame_b(2, -1, -1);
    step(1, 0, 0);
    step(1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gbc_vram_read_scheduler.md
Name: gbc_vram_read_scheduler

Overview:
- Sequences pixel-clock reads of the 160x144 GBC frame buffer for the 1280x720 VGA output.
- Integer-scales the source image (default x4, giving 640x576) and centres it on the raster.
- Generates VRAM read addresses incrementally, with no multiplier.
- Delays sync and active signals to match the VRAM read latency, and drives registered RGB332.

Parameters:
SRC_H, 160, source pixels per line
SRC_V, 144, source lines per frame
SCALE, 4, integer replication factor in both axes (>=1)
X_OFFSET, 320, first raster x of the window
Y_OFFSET, 72, first raster y of the window
ADDR_WIDTH, 15, VRAM address width
VRAM_LATENCY, 1, cycles from address to i_vramData valid

Ports:
i_clkPixel  input  1  pixel clock
i_reset  input  1  synchronous, active-high reset
i_hSync  input  1  raster hsync, timed with i_x
i_vSync  input  1  raster vsync, timed with i_y
i_active  input  1  raster active-video flag
i_x  input  16  raster column
i_y  input  16  raster row
i_vramData  input  8  VRAM read data, RGB332
o_vramReadAddr  output  ADDR_WIDTH  VRAM read address
o_hSync  output  1  delayed hsync
o_vSync  output  1  delayed vsync
o_inWindow  output  1  delayed window flag, aligned with RGB
o_red  output  3  red
o_green  output  3  green
o_blue  output  2  blue

Behaviour:
- Window: i_active && X_OFFSET <= i_x < X_OFFSET+SRC_H*SCALE && Y_OFFSET <= i_y < Y_OFFSET+SRC_V*SCALE.
- Registers: rowBase (ADDR_WIDTH), srcX (8 bits), xSub and ySub (each 0..SCALE-1), state.
- FSM states, all transitions on rising i_clkPixel:
  - S_TOP: rowBase=0, ySub=0. When i_y==Y_OFFSET and i_x==X_OFFSET-1, go to S_FETCH with srcX=0, xSub=0.
  - S_FETCH: each cycle, address = rowBase+srcX and xSub increments. On xSub==SCALE-1, xSub=0 and srcX increments. When srcX==SRC_H-1 and xSub==SCALE-1, go to S_LINE_END.
  - S_LINE_END: ySub increments. On ySub==SCALE-1, ySub=0 and rowBase+=SRC_H. If this was the last window line, go to S_BOTTOM; otherwise go to S_WAIT_X.
  - S_WAIT_X: when i_x==X_OFFSET-1, go to S_FETCH with srcX=0, xSub=0.
  - S_BOTTOM: idle until frame start.
- Frame start (i_x==0 && i_y==0) forces S_TOP from any state and clears all counters. This takes priority over every other transition.
- o_vramReadAddr:
  - Registered. Equals rowBase+srcX one cycle after the corresponding window coordinate appears on i_x/i_y.
  - Equals 0 outside S_FETCH.
  - Never exceeds SRC_H*SRC_V-1 (23039 at defaults).
- Pipeline: hSync, vSync and the window flag pass through a (2+VRAM_LATENCY)-stage shift register. Total latency from i_x/i_y to RGB outputs is 3 cycles at defaults.
- RGB: registered from i_vramData[7:5], [4:2], [1:0] when the delayed window flag is 1; otherwise 0.
- Reset (synchronous, active-high):
  - All outputs 0, all pipeline stages 0, state S_TOP.
  - Reset asserted mid-line aborts the fetch. After release, output stays black until the next frame start; no partial frame is shown.
- S_FETCH takes no account of i_active. The raster controller guarantees the window lies inside active video.

Optional Feature:
VRAM_SCANLINE_EN
- Defined: when the delayed ySub equals SCALE-1, each colour channel is shifted right by 1 (halved) before registering. This produces a dark scanline on the last replicated line of every source row. ySub is pipelined alongside the sync signals.
- Undefined: the ySub pipeline is absent and colour passes unmodified.

Test Plan:
- Reset held 5 cycles with stimulus active -> all outputs 0; after release, black until i_x=0,i_y=0.
- Raster (319,72)->(320,72)->...->(324,72) -> o_vramReadAddr 0 at cycle after (320,72), stays 0 for 4 cycles, 1 at cycle after (324,72); o_inWindow rises 3 cycles after (320,72).
- Line y=76, x=320 -> address 160; y=75, x=959 -> address 159; y=647, x=959 -> address 23039; x=960 -> address 0, RGB 0.
- i_vramData=8'hE5 inside window -> red=7, green=1, blue=1 three cycles later; outside window with the same data -> all 0.
- Reset pulsed at (500,300), then a full frame -> second frame's addresses match an unreset golden model exactly.
- VRAM_SCANLINE_EN defined, data 8'hFF at y=75 -> red=3, green=3, blue=1; at y=74 -> 7, 7, 3.
